// File: rtl/enc_add_scheduler.sv
// Sequencer for the encapsulation add stage: five serialised additions on one shared adder.
// Optional performance counters are enabled with `define ENC_ADD_SCHED_PERF_EN.
module enc_add_scheduler #(
   parameter int ADD_LATENCY = 1,
   parameter int NUM_STEPS   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [2:0]  mux_sel,
   output logic [1:0]  a_src,
   output logic        add_start,
   output logic        wr_en,
   output logic [1:0]  wr_idx,
   output logic [2:0]  step
`ifdef ENC_ADD_SCHED_PERF_EN
   ,
   output logic [15:0] run_cycles,
   output logic [7:0]  run_count
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
   localparam logic [3:0] WAIT_LAST = (ADD_LATENCY > 1) ? 4'(ADD_LATENCY - 2) : 4'd0;

   state_t     state, state_next;
   logic [2:0] step_idx, step_idx_next;
   logic [3:0] wait_cnt, wait_cnt_next;

   logic       tbl_valid;
   logic [2:0] tbl_mux;
   logic [1:0] tbl_asrc;
   logic [1:0] tbl_widx;

   logic       busy_d, done_d, add_start_d, wr_en_d;
   logic [2:0] mux_sel_d, step_d;
   logic [1:0] a_src_d, wr_idx_d;

   always_comb begin
      tbl_valid = 1'b1;
      tbl_mux   = 3'd0;
      tbl_asrc  = 2'd0;
      tbl_widx  = 2'd0;
      case (step_idx)
         3'd0: begin tbl_mux = 3'd1; tbl_asrc = 2'd0; tbl_widx = 2'd0; end
         3'd1: begin tbl_mux = 3'd2; tbl_asrc = 2'd1; tbl_widx = 2'd1; end
         3'd2: begin tbl_mux = 3'd3; tbl_asrc = 2'd2; tbl_widx = 2'd2; end
         3'd3: begin tbl_mux = 3'd0; tbl_asrc = 2'd3; tbl_widx = 2'd3; end
         3'd4: begin tbl_mux = 3'd4; tbl_asrc = 2'd3; tbl_widx = 2'd3; end
         default: tbl_valid = 1'b0;
      endcase
   end

   // Output values are decoded from the current state and registered one cycle later,
   // so each step's table is held on the outputs from add_start through wr_en.
   always_comb begin
      state_next    = state;
      step_idx_next = step_idx;
      wait_cnt_next = wait_cnt;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      add_start_d   = 1'b0;
      wr_en_d       = 1'b0;
      mux_sel_d     = 3'd0;
      a_src_d       = 2'd0;
      wr_idx_d      = 2'd0;
      step_d        = 3'd0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next    = ISSUE;
               step_idx_next = 3'd0;
            end
         end
         ISSUE: begin
            busy_d      = 1'b1;
            add_start_d = 1'b1;
            mux_sel_d   = tbl_mux;
            a_src_d     = tbl_asrc;
            wr_idx_d    = tbl_widx;
            step_d      = step_idx;
            if (ADD_LATENCY == 1) begin
               state_next = WRITE;
            end else begin
               state_next    = WAIT;
               wait_cnt_next = 4'd0;
            end
         end
         WAIT: begin
            busy_d    = 1'b1;
            mux_sel_d = tbl_mux;
            a_src_d   = tbl_asrc;
            wr_idx_d  = tbl_widx;
            step_d    = step_idx;
            if (wait_cnt == WAIT_LAST) begin
               state_next = WRITE;
            end else begin
               wait_cnt_next = wait_cnt + 4'd1;
            end
         end
         WRITE: begin
            busy_d    = 1'b1;
            wr_en_d   = tbl_valid;
            mux_sel_d = tbl_mux;
            a_src_d   = tbl_asrc;
            wr_idx_d  = tbl_widx;
            step_d    = step_idx;
            // Strict serialisation: step 4 reads the V bank written by step 3.
            if (step_idx == LAST_STEP) begin
               state_next = FIN;
            end else begin
               step_idx_next = step_idx + 3'd1;
               state_next    = ISSUE;
            end
         end
         FIN: begin
            done_d     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         step_idx <= 3'd0;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         step_idx <= step_idx_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         add_start <= 1'b0;
         wr_en     <= 1'b0;
         mux_sel   <= 3'd0;
         a_src     <= 2'd0;
         wr_idx    <= 2'd0;
         step      <= 3'd0;
      end else begin
         busy      <= busy_d;
         done      <= done_d;
         add_start <= add_start_d;
         wr_en     <= wr_en_d;
         mux_sel   <= mux_sel_d;
         a_src     <= a_src_d;
         wr_idx    <= wr_idx_d;
         step      <= step_d;
      end
   end

`ifdef ENC_ADD_SCHED_PERF_EN
   // busy_d is exactly the next-cycle busy output, so this counts busy cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cycles <= 16'd0;
         run_count  <= 8'd0;
      end else begin
         if (state == IDLE && start) begin
            run_cycles <= 16'd0;
         end else if (busy_d && run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
         end
         if (done_d) begin
            run_count <= run_count + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_enc_add_scheduler.sv
// Directed self-checking bench for enc_add_scheduler at ADD_LATENCY=1 and ADD_LATENCY=3.
// Performance counter checks are included when ENC_ADD_SCHED_PERF_EN is defined.
module tb_enc_add_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start1, start3;
   logic       busy1, done1, add_start1, wr_en1;
   logic [2:0] mux_sel1, step1;
   logic [1:0] a_src1, wr_idx1;
   logic       busy3, done3, add_start3, wr_en3;
   logic [2:0] mux_sel3, step3;
   logic [1:0] a_src3, wr_idx3;
`ifdef ENC_ADD_SCHED_PERF_EN
   logic [15:0] run_cycles1, run_cycles3;
   logic [7:0]  run_count1, run_count3;
`endif

   int errors = 0;
   int checks = 0;

   int exp_mux[5]  = '{1, 2, 3, 0, 4};
   int exp_asrc[5] = '{0, 1, 2, 3, 3};
   int exp_widx[5] = '{0, 1, 2, 3, 3};

   enc_add_scheduler #(.ADD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .busy(busy1), .done(done1), .mux_sel(mux_sel1), .a_src(a_src1),
      .add_start(add_start1), .wr_en(wr_en1), .wr_idx(wr_idx1), .step(step1)
`ifdef ENC_ADD_SCHED_PERF_EN
      , .run_cycles(run_cycles1), .run_count(run_count1)
`endif
   );

   enc_add_scheduler #(.ADD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
      .busy(busy3), .done(done3), .mux_sel(mux_sel3), .a_src(a_src3),
      .add_start(add_start3), .wr_en(wr_en3), .wr_idx(wr_idx3), .step(step3)
`ifdef ENC_ADD_SCHED_PERF_EN
      , .run_cycles(run_cycles3), .run_count(run_count3)
`endif
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start1 so it is sampled at edge 0, then checks cycles 1..11.
   task automatic apply_stimulus_run1(input string tag);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check_output({tag, "_c0_busy"}, 32'(busy1), 0);
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k <= 10) begin
            int s;
            s = (k - 1) / 2;
            check_output($sformatf("%s_c%0d_add_start", tag, k), 32'(add_start1), 32'(k % 2 == 1));
            check_output($sformatf("%s_c%0d_wr_en", tag, k), 32'(wr_en1), 32'(k % 2 == 0));
            check_output($sformatf("%s_c%0d_mux_sel", tag, k), 32'(mux_sel1), exp_mux[s]);
            check_output($sformatf("%s_c%0d_a_src", tag, k), 32'(a_src1), exp_asrc[s]);
            check_output($sformatf("%s_c%0d_wr_idx", tag, k), 32'(wr_idx1), exp_widx[s]);
            check_output($sformatf("%s_c%0d_step", tag, k), 32'(step1), s);
            check_output($sformatf("%s_c%0d_busy", tag, k), 32'(busy1), 1);
            check_output($sformatf("%s_c%0d_done", tag, k), 32'(done1), 0);
         end else begin
            check_output({tag, "_c11_done"}, 32'(done1), 1);
            check_output({tag, "_c11_busy"}, 32'(busy1), 0);
            check_output({tag, "_c11_wr_en"}, 32'(wr_en1), 0);
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      repeat (2) tick();
      check_output("rst_busy", 32'(busy1), 0);
      check_output("rst_done", 32'(done1), 0);
      check_output("rst_add_start", 32'(add_start1), 0);
      check_output("rst_wr_en", 32'(wr_en1), 0);
      check_output("rst_mux_sel", 32'(mux_sel1), 0);
      check_output("rst_step", 32'(step1), 0);
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("rst_run_cycles", 32'(run_cycles1), 0);
      check_output("rst_run_count", 32'(run_count1), 0);
`endif
      rst_n = 1'b1;
      tick();

      $display("[TB] basic run, ADD_LATENCY=1");
      apply_stimulus_run1("basic");
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("basic_run_cycles", 32'(run_cycles1), 10);
      check_output("basic_run_count", 32'(run_count1), 1);
`endif
      tick();

      $display("[TB] basic run, ADD_LATENCY=3");
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k <= 20) begin
            int s, ph;
            s  = (k - 1) / 4;
            ph = (k - 1) % 4;
            check_output($sformatf("lat3_c%0d_add_start", k), 32'(add_start3), 32'(ph == 0));
            check_output($sformatf("lat3_c%0d_wr_en", k), 32'(wr_en3), 32'(ph == 3));
            check_output($sformatf("lat3_c%0d_mux_sel", k), 32'(mux_sel3), exp_mux[s]);
            check_output($sformatf("lat3_c%0d_wr_idx", k), 32'(wr_idx3), exp_widx[s]);
            check_output($sformatf("lat3_c%0d_busy", k), 32'(busy3), 1);
            check_output($sformatf("lat3_c%0d_done", k), 32'(done3), 0);
         end else begin
            check_output("lat3_c21_done", 32'(done3), 1);
            check_output("lat3_c21_busy", 32'(busy3), 0);
         end
      end
      tick();

      $display("[TB] start held high for 20 cycles");
      start1 = 1'b1;
      tick();
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (k == 10) check_output("hold_c10_done", 32'(done1), 0);
         if (k == 11) check_output("hold_c11_done", 32'(done1), 1);
         if (k == 12) begin
            check_output("hold_c12_busy", 32'(busy1), 0);
            check_output("hold_c12_add_start", 32'(add_start1), 0);
         end
         if (k == 13) begin
            check_output("hold_c13_busy", 32'(busy1), 1);
            check_output("hold_c13_add_start", 32'(add_start1), 1);
            check_output("hold_c13_step", 32'(step1), 0);
         end
         if (k == 22) check_output("hold_c22_done", 32'(done1), 0);
         if (k == 23) check_output("hold_c23_done", 32'(done1), 1);
         if (k == 24) check_output("hold_c24_busy", 32'(busy1), 0);
         if (k == 25) check_output("hold_c25_busy", 32'(busy1), 0);
         if (k == 19) start1 = 1'b0;
      end
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("hold_run_count", 32'(run_count1), 3);
`endif

      $display("[TB] reset mid-sequence");
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (6) tick();
      check_output("midrst_pre_busy", 32'(busy1), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_output("midrst_busy", 32'(busy1), 0);
      check_output("midrst_wr_en", 32'(wr_en1), 0);
      check_output("midrst_add_start", 32'(add_start1), 0);
      check_output("midrst_mux_sel", 32'(mux_sel1), 0);
      check_output("midrst_a_src", 32'(a_src1), 0);
      check_output("midrst_wr_idx", 32'(wr_idx1), 0);
      check_output("midrst_step", 32'(step1), 0);
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("midrst_run_cycles", 32'(run_cycles1), 0);
      check_output("midrst_run_count", 32'(run_count1), 0);
`endif
      repeat (3) tick();
      check_output("midrst_hold_wr_en", 32'(wr_en1), 0);
      check_output("midrst_hold_done", 32'(done1), 0);
      rst_n = 1'b1;
      tick();
      check_output("midrst_idle_busy", 32'(busy1), 0);

      apply_stimulus_run1("clean1");
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("clean1_run_cycles", 32'(run_cycles1), 10);
      check_output("clean1_run_count", 32'(run_count1), 1);
`endif
      apply_stimulus_run1("clean2");
`ifdef ENC_ADD_SCHED_PERF_EN
      check_output("clean2_run_cycles", 32'(run_cycles1), 10);
      check_output("clean2_run_count", 32'(run_count1), 2);
      tick();
      check_output("after_run_cycles_hold", 32'(run_cycles1), 10);
      rst_n = 1'b0;
      #1;
      check_output("final_rst_run_cycles", 32'(run_cycles1), 0);
      check_output("final_rst_run_count", 32'(run_count1), 0);
      rst_n = 1'b1;
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enc_add_scheduler.md
Name: enc_add_scheduler

Overview:
- Sequences the encapsulation add stage: one shared CLA polynomial adder, whose operand B comes from the 5:1 small-poly multiplexer, performs five polynomial additions.
- u[i] = invntt_u[i] + e_1[i] for i = 0..2.
- v = (invntt_v + e_2) + msg_poly.
- Drives the mux selector, the operand-A source select, the adder start, and the result-bank write strobes. Reports busy/done to the top-level encaps FSM.

Parameters:
- ADD_LATENCY, 1: cycles from add_start to a valid adder result. Legal range 1..15.
- NUM_STEPS, 5: additions per run. Fixed by Kyber-768 (k=3 plus 2). Not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to run the add sequence
- busy  output  1  high while a sequence is in progress
- done  output  1  single-cycle pulse when the sequence completes
- mux_sel  output  3  selector to the 5:1 small mux (0=e_2, 1..3=e_1[0..2], 4=msg_poly)
- a_src  output  2  operand-A select (0..2=invntt_u[0..2], 3=V bank register)
- add_start  output  1  single-cycle pulse launching one addition
- wr_en  output  1  single-cycle pulse: write adder result to the result bank
- wr_idx  output  2  destination bank (0..2=u[0..2], 3=v)
- step  output  3  current step index 0..4, for debug

Behaviour:
- Reset (async, rst_n low), all outputs: busy=0, done=0, add_start=0, wr_en=0, mux_sel=0, a_src=0, wr_idx=0, step=0. FSM goes to IDLE.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 → ISSUE, step=0, busy=1.
  - ISSUE (1 cycle): drive the step table, add_start=1 → WAIT.
  - WAIT: ADD_LATENCY-1 cycles; skipped when ADD_LATENCY=1 → WRITE.
  - WRITE (1 cycle): wr_en=1. If step==4 → FIN, otherwise step+1 → ISSUE.
  - FIN (1 cycle): done=1, busy=0 → IDLE.
- Step table (mux_sel, a_src, wr_idx):
  - step 0: 1, 0, 0
  - step 1: 2, 1, 1
  - step 2: 3, 2, 2
  - step 3: 0, 3, 3
  - step 4: 4, 3, 3
- Step 3 must have its wr_en committed before step 4 issues. This RAW dependency on the V bank is met by strict serialisation; no overlap is allowed.
- Before start, the top-level preloads the V bank with invntt_v. The scheduler does not load it.
- mux_sel, a_src and wr_idx are stable from ISSUE through WRITE of the same step.
- add_start rises exactly ADD_LATENCY cycles before wr_en.
- Cycles per step = ADD_LATENCY+1. Total from start to done pulse = 1 + 5*(ADD_LATENCY+1) cycles. ADD_LATENCY=1 gives done at cycle 11 after the start edge.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as the FIN state is ignored. A restart is accepted the cycle after done.
- Reset mid-sequence: immediate return to IDLE; no wr_en or done is generated. The result bank contents are then undefined to the top level.
- Out-of-table indices never occur. The default branch drives mux_sel=0, a_src=0 and does not assert wr_en.

Optional Feature:
- Macro: ENC_ADD_SCHED_PERF_EN.
- Enabled:
  - Adds output run_cycles[15:0]: counts clk cycles while busy=1.
  - Clears on an accepted start and holds after done. Reset value 0.
  - Saturates at 16'hFFFF.
  - Adds output run_count[7:0]: completed runs, wraps at 255 to 0.
- Disabled: neither port exists; all other behaviour is identical.

Test Plan:
- Basic run, ADD_LATENCY=1: start pulse at cycle 0 → add_start at cycles 1,3,5,7,9. wr_en at 2,4,6,8,10 with wr_idx 0,1,2,3,3. mux_sel 1,2,3,0,4. done at 11; busy high cycles 1..10.
- ADD_LATENCY=3: start → add_start-to-wr_en gap is 3 cycles every step. done 21 cycles after start. Tables held stable during WAIT.
- start held high for 20 cycles → exactly one sequence runs and a second is accepted only after done. With start still high at cycle 12, a second run begins.
- rst_n low at cycle 6 of a run (async, mid-clock) → all outputs 0 immediately. No further wr_en; a later start runs a clean sequence from step 0.
- End-to-end with adder, mux and bank: e_1 coeff 3'b111 added to invntt_u[0] coeff 5 → u[0] coeff 4. V = 100 + e_2(3'b110 → 3327) + msg 1665 → (100+3327+1665) mod 3329 = 1763.
- With ENC_ADD_SCHED_PERF_EN, ADD_LATENCY=1: after two runs → run_cycles=10, run_count=2. After reset → both 0.
